// File: rtl/alu_seg_pipe.sv
// alu_seg_pipe: pipelined ALU for the sail core. Add/sub is split into NSEG carry-chained
// segments (one per stage); every other op rides the same pipe so results stay in order.
module alu_seg_pipe #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned SEG_WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       alu_ctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             branch_enable
);
    localparam int unsigned NSEG = WIDTH / SEG_WIDTH;
    localparam int unsigned SHW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned SW1  = SEG_WIDTH + 1;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SRL   = 4'b0011;
    localparam logic [3:0] OP_SRA   = 4'b0100;
    localparam logic [3:0] OP_XOR   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLL   = 4'b1000;
    localparam logic [3:0] OP_CSRRW = 4'b1001;
    localparam logic [3:0] OP_CSRRS = 4'b1010;
    localparam logic [3:0] OP_CSRRC = 4'b1011;

    localparam logic [2:0] BR_BEQ  = 3'b001;
    localparam logic [2:0] BR_BNE  = 3'b010;
    localparam logic [2:0] BR_BLT  = 3'b011;
    localparam logic [2:0] BR_BGE  = 3'b100;
    localparam logic [2:0] BR_BLTU = 3'b101;
    localparam logic [2:0] BR_BGEU = 3'b110;

    typedef struct packed {
        logic             arith;
        logic [2:0]       br;
        logic             a_msb;
        logic             b_msb;
        logic             carry;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] res;
    } stage_t;

    stage_t          st_q [NSEG];
    stage_t          st_d [NSEG];
    stage_t          src  [NSEG];
    stage_t          s0_in;
    logic [NSEG-1:0] valid_q;
    logic [NSEG-1:0] valid_d;
    logic [NSEG-1:0] src_valid;
    logic [NSEG-1:0] adv;
    logic [NSEG-1:0] load;
    logic            be_q;
    logic            be_d;
    logic [3:0]      op;
    logic [2:0]      br;
    logic [SHW-1:0]  shamt;
    logic            is_branch;
    logic            is_sub;
    logic            is_add;
    logic [WIDTH-1:0] logic_res;

    // Decode and non-arithmetic ops, all resolved before entering S0.
    always_comb begin
        op        = alu_ctl[3:0];
        br        = alu_ctl[6:4];
        shamt     = b[SHW-1:0];
        is_branch = (br >= BR_BEQ) && (br <= BR_BGEU);
        is_sub    = is_branch || (op == OP_SUB);
        is_add    = !is_branch && (op == OP_ADD);
        case (op)
            OP_AND:   logic_res = a & b;
            OP_OR:    logic_res = a | b;
            OP_XOR:   logic_res = a ^ b;
            OP_SLT:   logic_res = WIDTH'($signed(a) < $signed(b));
            OP_SRL:   logic_res = a >> shamt;
            OP_SRA:   logic_res = WIDTH'($signed(a) >>> shamt);
            OP_SLL:   logic_res = a << shamt;
            OP_CSRRW: logic_res = a;
            OP_CSRRS: logic_res = a | b;
            OP_CSRRC: logic_res = ~a & b;
            default:  logic_res = '0;
        endcase
        s0_in.arith = is_sub || is_add;
        s0_in.br    = br;
        s0_in.a_msb = a[WIDTH-1];
        s0_in.b_msb = b[WIDTH-1];
        s0_in.carry = is_sub;
        s0_in.a     = a;
        s0_in.b     = is_sub ? ~b : b;
        s0_in.res   = (is_sub || is_add) ? '0 : logic_res;
    end

    // Flow control, per-stage segment add, and branch resolution on the final result.
    always_comb begin
        logic full_tail;
        full_tail = 1'b1;
        for (int k = int'(NSEG) - 1; k >= 0; k--) begin
            full_tail = full_tail & valid_q[k];
            adv[k]    = out_ready | ~full_tail;
        end

        src[0]       = s0_in;
        src_valid[0] = in_valid;
        for (int k = 1; k < int'(NSEG); k++) begin
            src[k]       = st_q[k-1];
            src_valid[k] = valid_q[k-1];
        end

        for (int k = 0; k < int'(NSEG); k++) begin
            logic [SEG_WIDTH:0] sum;
            sum = {1'b0, src[k].a[k*SEG_WIDTH +: SEG_WIDTH]}
                + {1'b0, src[k].b[k*SEG_WIDTH +: SEG_WIDTH]}
                + SW1'(src[k].carry);
            st_d[k] = src[k];
            if (src[k].arith) begin
                st_d[k].res[k*SEG_WIDTH +: SEG_WIDTH] = sum[SEG_WIDTH-1:0];
                st_d[k].carry                         = sum[SEG_WIDTH];
            end
            load[k]    = adv[k] & src_valid[k] & ~flush;
            valid_d[k] = flush ? 1'b0 : (adv[k] ? src_valid[k] : valid_q[k]);
        end

        case (st_d[NSEG-1].br)
            BR_BEQ:  be_d = (st_d[NSEG-1].res == '0);
            BR_BNE:  be_d = (st_d[NSEG-1].res != '0);
            BR_BLT:  be_d = (st_d[NSEG-1].a_msb != st_d[NSEG-1].b_msb) ? st_d[NSEG-1].a_msb
                                                                       : st_d[NSEG-1].res[WIDTH-1];
            BR_BGE:  be_d = (st_d[NSEG-1].a_msb != st_d[NSEG-1].b_msb) ? ~st_d[NSEG-1].a_msb
                                                                       : ~st_d[NSEG-1].res[WIDTH-1];
            BR_BLTU: be_d = ~st_d[NSEG-1].carry;
            BR_BGEU: be_d = st_d[NSEG-1].carry;
            default: be_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            be_q    <= 1'b0;
            for (int k = 0; k < int'(NSEG); k++) st_q[k] <= '0;
        end else begin
            valid_q <= valid_d;
            if (load[NSEG-1]) be_q <= be_d;
            for (int k = 0; k < int'(NSEG); k++) begin
                if (load[k]) st_q[k] <= st_d[k];
            end
        end
    end

    assign in_ready      = adv[0];
    assign out_valid     = valid_q[NSEG-1];
    assign alu_out       = st_q[NSEG-1].res;
    assign branch_enable = be_q;
endmodule

// File: tb/tb_alu_seg_pipe.sv
// Scoreboard bench for alu_seg_pipe: default (NSEG=2) and SEG_WIDTH=8 (NSEG=4) instances.
module tb_alu_seg_pipe;
    localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010, OP_SRL = 4'b0011;
    localparam logic [3:0] OP_SRA = 4'b0100, OP_XOR = 4'b0101, OP_SUB = 4'b0110, OP_SLT = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b1000, OP_CSRRW = 4'b1001, OP_CSRRS = 4'b1010, OP_CSRRC = 4'b1011;
    localparam logic [2:0] BR_NO = 3'b000, BR_BEQ = 3'b001, BR_BNE = 3'b010, BR_BLT = 3'b011;
    localparam logic [2:0] BR_BGE = 3'b100, BR_BLTU = 3'b101, BR_BGEU = 3'b110;

    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, out_ready = 1'b1;
    logic        iv0 = 1'b0, iv1 = 1'b0;
    logic [6:0]  ctl = '0;
    logic [31:0] a = '0, b = '0;
    logic        ir0, ov0, be0, ir1, ov1, be1;
    logic [31:0] r0, r1;
    int          tests = 0, fails = 0, cyc = 0;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic        be;
        logic        chk_be;
        logic        chk_lat;
        int          acc;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];

    typedef struct packed {
        logic [6:0]  c;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] r;
        logic        e;
        logic        cb;
    } vec_t;
    vec_t vt[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_seg_pipe dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv0), .in_ready(ir0),
        .alu_ctl(ctl), .a(a), .b(b), .out_valid(ov0), .out_ready(out_ready),
        .alu_out(r0), .branch_enable(be0)
    );

    alu_seg_pipe #(.WIDTH(32), .SEG_WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv1), .in_ready(ir1),
        .alu_ctl(ctl), .a(a), .b(b), .out_valid(ov1), .out_ready(out_ready),
        .alu_out(r1), .branch_enable(be1)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic score(input exp_t e, input logic [31:0] r, input logic be, input int nseg);
        chk($sformatf("res%0d", e.id), r, e.res);
        if (e.chk_be) chk($sformatf("be%0d", e.id), 32'(be), 32'(e.be));
        if (e.chk_lat) chk($sformatf("lat%0d", e.id), 32'(cyc - e.acc), 32'(nseg));
    endtask

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n && ov0 && out_ready) begin
            if (q0.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected0 got=%h exp=none", r0);
            end else begin
                e = q0.pop_front();
                score(e, r0, be0, 2);
            end
        end
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n && ov1 && out_ready) begin
            if (q1.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected1 got=%h exp=none", r1);
            end else begin
                e = q1.pop_front();
                score(e, r1, be1, 4);
            end
        end
    end

    // Offer one op; push its expectation once the accept edge has passed.
    task automatic send(input int which, input int id, input logic [6:0] c, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] er, input logic eb,
                        input logic cb, input logic cl);
        exp_t e;
        bit   acc;
        int   n;
        ctl = c; a = x; b = y;
        if (which == 0) iv0 = 1'b1; else iv1 = 1'b1;
        acc = 1'b0; n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = (which == 0) ? ir0 : ir1;
            e.id = id; e.res = er; e.be = eb; e.chk_be = cb; e.chk_lat = cl; e.acc = cyc;
            @(posedge clk); #1;
            n++;
        end
        iv0 = 1'b0; iv1 = 1'b0;
        if (acc) begin
            if (which == 0) q0.push_back(e); else q1.push_back(e);
        end else begin
            tests++; fails++;
            $display("FAIL accept%0d got=stalled exp=accepted", id);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (q0.size() != 0 || q1.size() != 0) begin
            tests++; fails++;
            $display("FAIL drain got=%0d exp=0", q0.size() + q1.size());
        end
    endtask

    initial begin
        #100000;
        fails++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        vt.push_back('{{BR_NO, OP_AND},   32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1'b0, 1'b0});
        vt.push_back('{{BR_NO, OP_OR},    32'hF0000000, 32'h0000000F, 32'hF000000F, 1'b0, 1'b0});
        vt.push_back('{{BR_NO, OP_SLT},   32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0});
        vt.push_back('{{BR_NO, OP_SLT},   32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0});
        vt.push_back('{{BR_NO, OP_SRL},   32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 1'b0});
        vt.push_back('{{BR_NO, OP_SLL},   32'h00000001, 32'h00000025, 32'h00000020, 1'b0, 1'b0});
        vt.push_back('{{BR_NO, OP_CSRRW}, 32'hCAFEBABE, 32'h00000001, 32'hCAFEBABE, 1'b0, 1'b0});
        vt.push_back('{{BR_NO, OP_CSRRS}, 32'h0000F000, 32'h0000000F, 32'h0000F00F, 1'b0, 1'b0});
        vt.push_back('{{BR_NO, OP_CSRRC}, 32'h0000FFFF, 32'hFFFFFFFF, 32'hFFFF0000, 1'b0, 1'b0});
        vt.push_back('{{BR_NO, 4'b1111},  32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b0});
        vt.push_back('{{BR_NO, OP_SUB},   32'h00010000, 32'h00000001, 32'h0000FFFF, 1'b0, 1'b0});
        vt.push_back('{{BR_NO, OP_ADD},   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0});
        vt.push_back('{{BR_BNE, OP_SUB},  32'h00000005, 32'h00000003, 32'h00000002, 1'b1, 1'b1});
        vt.push_back('{{BR_BGE, OP_SUB},  32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 1'b1});
        vt.push_back('{{BR_BGEU, OP_SUB}, 32'h00000005, 32'h00000003, 32'h00000002, 1'b1, 1'b1});
        vt.push_back('{{BR_BLT, OP_SUB},  32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b1, 1'b1});
        vt.push_back('{{BR_BEQ, OP_SUB},  32'h00000001, 32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b1});

        #12 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(ov0), 32'd0);
        chk("rst_alu_out", r0, 32'd0);
        chk("rst_branch", 32'(be0), 32'd0);
        chk("rst_in_ready", 32'(ir0), 32'd1);
        chk("rst_out_valid8", 32'(ov1), 32'd0);
        chk("rst_alu_out8", r1, 32'd0);
        @(posedge clk); #1;

        send(0, 1, {BR_NO, OP_ADD}, 32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b0, 1'b0, 1'b1);
        drain();
        send(0, 2, {BR_BLTU, OP_SUB}, 32'h00000001, 32'hFFFFFFFF, 32'h00000002, 1'b1, 1'b1, 1'b1);
        send(0, 3, {BR_BLT, OP_SUB},  32'h00000001, 32'hFFFFFFFF, 32'h00000002, 1'b0, 1'b1, 1'b1);
        drain();

        send(0, 4, {BR_NO, OP_ADD},  32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b0, 1'b1);
        send(0, 5, {BR_NO, OP_XOR},  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0, 1'b0, 1'b1);
        send(0, 6, {BR_NO, OP_SRA},  32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 1'b0, 1'b1);
        send(0, 7, {BR_BEQ, OP_SUB}, 32'h00001234, 32'h00001234, 32'h00000000, 1'b1, 1'b1, 1'b1);
        drain();

        for (int i = 0; i < vt.size(); i++)
            send(0, 10 + i, vt[i].c, vt[i].x, vt[i].y, vt[i].r, vt[i].e, vt[i].cb, 1'b1);
        drain();

        // Backpressure: fill the pipe while the consumer stalls.
        out_ready = 1'b0;
        fork
            begin
                send(0, 40, {BR_NO, OP_ADD}, 32'h00000001, 32'h00000002, 32'h00000003, 1'b0, 1'b1, 1'b0);
                send(0, 41, {BR_NO, OP_XOR}, 32'hAAAA0000, 32'h0000AAAA, 32'hAAAAAAAA, 1'b0, 1'b0, 1'b0);
                send(0, 42, {BR_NO, OP_AND}, 32'h000000FF, 32'h0000000F, 32'h0000000F, 1'b0, 1'b0, 1'b0);
            end
        join_none
        repeat (3) @(posedge clk);
        repeat (5) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(ov0), 32'd1);
            chk("bp_alu_out", r0, 32'h00000003);
            chk("bp_branch", 32'(be0), 32'd0);
            chk("bp_in_ready", 32'(ir0), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        #50;
        drain();

        // Flush kills both in-flight ops and ignores the op offered alongside it.
        out_ready = 1'b0;
        send(0, 50, {BR_NO, OP_ADD}, 32'h0000000A, 32'h00000014, 32'h0000001E, 1'b0, 1'b0, 1'b0);
        send(0, 51, {BR_NO, OP_OR},  32'h00000100, 32'h00000001, 32'h00000101, 1'b0, 1'b0, 1'b0);
        flush = 1'b1; iv0 = 1'b1; ctl = {BR_NO, OP_ADD}; a = 32'd7; b = 32'd8;
        @(posedge clk); #1;
        flush = 1'b0; iv0 = 1'b0;
        q0.delete();
        out_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("flush_no_valid", 32'(ov0), 32'd0);
        end
        @(posedge clk); #1;

        // Asynchronous reset while an ADD sits at the output.
        out_ready = 1'b0;
        send(0, 60, {BR_NO, OP_ADD}, 32'h00000005, 32'h00000006, 32'h0000000B, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("pre_rst_valid", 32'(ov0), 32'd1);
        chk("pre_rst_alu_out", r0, 32'h0000000B);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(ov0), 32'd0);
        chk("async_rst_alu_out", r0, 32'd0);
        chk("async_rst_branch", 32'(be0), 32'd0);
        q0.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_valid", 32'(ov0), 32'd0);
        end
        chk("post_rst_in_ready", 32'(ir0), 32'd1);
        @(posedge clk); #1;

        // Four 8-bit segments.
        send(1, 70, {BR_NO, OP_ADD},   32'h00FFFFFF, 32'h00000001, 32'h01000000, 1'b0, 1'b0, 1'b1);
        send(1, 71, {BR_NO, OP_ADD},   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b1);
        send(1, 72, {BR_BLTU, OP_SUB}, 32'h00000001, 32'hFFFFFFFF, 32'h00000002, 1'b1, 1'b1, 1'b1);
        send(1, 73, {BR_NO, OP_SUB},   32'h01000000, 32'h00000001, 32'h00FFFFFF, 1'b0, 1'b0, 1'b1);
        drain();

        chk("q0_empty", 32'(q0.size()), 32'd0);
        chk("q1_empty", 32'(q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
